// File: rtl/float2int_expand.sv
// Iterative decoder for 7-bit compressed-float codes (exponent/mantissa) into
// an unsigned integer: one left shift per cycle, valid/ready on both sides.
module float2int_expand #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4,
    parameter int OUT_W = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W-1:0] in_code,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic                   busy
);

    // The result width must hold {1,m} shifted by the largest exponent exactly.
    generate
        if (OUT_W != MAN_W + (1 << EXP_W) - 1) begin : g_bad_cfg
            $error("float2int_expand: OUT_W must equal MAN_W + 2**EXP_W - 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [EXP_W-1:0]   cnt_q, cnt_d;

    logic [EXP_W-1:0]   code_exp;
    logic [MAN_W-1:0]   code_man;
    logic [OUT_W-1:0]   load_acc;
    logic [EXP_W-1:0]   load_cnt;
    logic               accept;

    assign code_exp = in_code[EXP_W+MAN_W-1:MAN_W];
    assign code_man = in_code[MAN_W-1:0];

    // Exponent 0 is the denormal range: no implicit leading one, no shifts.
    assign load_acc = (code_exp == '0) ? OUT_W'(code_man) : OUT_W'({1'b1, code_man});
    assign load_cnt = (code_exp == '0) ? '0 : code_exp - EXP_W'(1);

    assign in_ready  = !rst && (state_q == IDLE || (state_q == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign out_data  = acc_q;
    assign busy      = (state_q == SHIFT);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = load_acc;
                    cnt_d   = load_cnt;
                    state_d = (load_cnt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                acc_d = acc_q << 1;
                cnt_d = cnt_q - EXP_W'(1);
                if (cnt_q == EXP_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // A transfer may coincide with the next accept, so no bubble.
                if (accept) begin
                    acc_d   = load_acc;
                    cnt_d   = load_cnt;
                    state_d = (load_cnt == '0) ? DONE : SHIFT;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
